// File: rtl/gpio_port_ctrl_pkg.sv
// +--------------------------------------------------------------------------+
// | gpio_port_ctrl_pkg                                                       |
// | Register offsets, polarity encodings and address helper for the GPIO     |
// | port controller.                                                         |
// | Rev 1.0  initial release                                                 |
// +--------------------------------------------------------------------------+
`default_nettype none

package gpio_port_ctrl_pkg;

    localparam logic [7:0] GPIO_DATA_IN    = 8'h00;
    localparam logic [7:0] GPIO_DATA_OUT   = 8'h04;
    localparam logic [7:0] GPIO_DIR        = 8'h08;
    localparam logic [7:0] GPIO_IRQ_EN     = 8'h0C;
    localparam logic [7:0] GPIO_IRQ_POL    = 8'h10;
    localparam logic [7:0] GPIO_IRQ_STATUS = 8'h14;

    localparam logic POL_RISING  = 1'b0;
    localparam logic POL_FALLING = 1'b1;

    // Byte lanes within a word all alias to the same register.
    function automatic logic [7:0] reg_offset(input logic [7:0] addr);
        return {addr[7:2], 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/gpio_port_ctrl_if.sv
// +--------------------------------------------------------------------------+
// | gpio_port_ctrl_if                                                        |
// | Core data-bus interface for the GPIO port controller.                    |
// | Rev 1.0  initial release                                                 |
// +--------------------------------------------------------------------------+
`default_nettype none

interface gpio_port_ctrl_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) ();

    logic [ADDR_WIDTH-1:0] bus_addr;
    logic [DATA_WIDTH-1:0] bus_wdata;
    logic                  bus_we;
    logic                  bus_re;
    logic [DATA_WIDTH-1:0] bus_rdata;
    logic                  bus_rvalid;

    modport master (
        output bus_addr,
        output bus_wdata,
        output bus_we,
        output bus_re,
        input  bus_rdata,
        input  bus_rvalid
    );

    modport slave (
        input  bus_addr,
        input  bus_wdata,
        input  bus_we,
        input  bus_re,
        output bus_rdata,
        output bus_rvalid
    );

endinterface

`default_nettype wire

// File: rtl/gpio_port_ctrl_sync_edge.sv
// +--------------------------------------------------------------------------+
// | gpio_sync_edge                                                           |
// | Multi-stage input synchroniser with delayed copy and per-pin             |
// | polarity-selected edge pulse.                                            |
// | Rev 1.0  initial release                                                 |
// +--------------------------------------------------------------------------+
`default_nettype none

module gpio_sync_edge
    import gpio_port_ctrl_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pin_i,
    input  logic [WIDTH-1:0] pol_i,
    output logic [WIDTH-1:0] data_in_o,
    output logic [WIDTH-1:0] edge_o
);

    // Stage 0 is the flop nearest the pins; the last stage is DATA_IN.
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  prev_q;
    logic [WIDTH-1:0]                  w_rise;
    logic [WIDTH-1:0]                  w_fall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign data_in_o = sync_q[SYNC_STAGES-1];
    assign w_rise    = data_in_o & ~prev_q;
    assign w_fall    = ~data_in_o & prev_q;

    always_comb begin
        edge_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            edge_o[i] = (pol_i[i] == POL_FALLING) ? w_fall[i] : w_rise[i];
        end
    end

endmodule

`default_nettype wire

// File: rtl/gpio_port_ctrl.sv
// +--------------------------------------------------------------------------+
// | gpio_port_ctrl                                                           |
// | Memory-mapped GPIO controller: direction/output registers, synchronised  |
// | inputs, edge-triggered sticky interrupt status and a level irq line.     |
// | Rev 1.0  initial release                                                 |
// +--------------------------------------------------------------------------+
`default_nettype none

module gpio_port_ctrl
    import gpio_port_ctrl_pkg::*;
#(
    parameter int GPIO_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    gpio_port_ctrl_if.slave       bus,
    input  logic [GPIO_WIDTH-1:0] gpio_port_in,
    output logic [GPIO_WIDTH-1:0] gpio_port_out,
    output logic [GPIO_WIDTH-1:0] gpio_port_oe,
    output logic                  irq
);

    logic [GPIO_WIDTH-1:0] w_data_in;
    logic [GPIO_WIDTH-1:0] w_edge;
    logic [GPIO_WIDTH-1:0] w_wdata;
    logic [7:0]            w_off;
    logic                  w_wr_out;
    logic                  w_wr_dir;
    logic                  w_wr_en;
    logic                  w_wr_pol;
    logic                  w_wr_st;
    logic                  w_unused_wdata;

    logic [GPIO_WIDTH-1:0] data_out_q;
    logic [GPIO_WIDTH-1:0] dir_q;
    logic [GPIO_WIDTH-1:0] irq_en_q;
    logic [GPIO_WIDTH-1:0] irq_en_d;
    logic [GPIO_WIDTH-1:0] irq_pol_q;
    logic [GPIO_WIDTH-1:0] irq_status_q;
    logic [GPIO_WIDTH-1:0] irq_status_d;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] rdata_d;
    logic                  rvalid_q;
    logic                  irq_q;

    gpio_sync_edge #(
        .WIDTH       (GPIO_WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk       (clk),
        .reset     (reset),
        .pin_i     (gpio_port_in),
        .pol_i     (irq_pol_q),
        .data_in_o (w_data_in),
        .edge_o    (w_edge)
    );

    assign w_off          = reg_offset(8'(bus.bus_addr));
    assign w_wdata        = bus.bus_wdata[GPIO_WIDTH-1:0];
    assign w_unused_wdata = ^bus.bus_wdata;

    assign w_wr_out = bus.bus_we && (w_off == GPIO_DATA_OUT);
    assign w_wr_dir = bus.bus_we && (w_off == GPIO_DIR);
    assign w_wr_en  = bus.bus_we && (w_off == GPIO_IRQ_EN);
    assign w_wr_pol = bus.bus_we && (w_off == GPIO_IRQ_POL);
    assign w_wr_st  = bus.bus_we && (w_off == GPIO_IRQ_STATUS);

    // New edges are OR-ed in after the clear so a coincident edge survives.
    always_comb begin
        irq_en_d     = w_wr_en ? w_wdata : irq_en_q;
        irq_status_d = (irq_status_q & ~(w_wr_st ? w_wdata : '0)) | w_edge;
    end

    always_comb begin
        rdata_d = '0;
        if (bus.bus_re) begin
            case (w_off)
                GPIO_DATA_IN:    rdata_d = DATA_WIDTH'(w_data_in);
                GPIO_DATA_OUT:   rdata_d = DATA_WIDTH'(data_out_q);
                GPIO_DIR:        rdata_d = DATA_WIDTH'(dir_q);
                GPIO_IRQ_EN:     rdata_d = DATA_WIDTH'(irq_en_q);
                GPIO_IRQ_POL:    rdata_d = DATA_WIDTH'(irq_pol_q);
                GPIO_IRQ_STATUS: rdata_d = DATA_WIDTH'(irq_status_q);
                default:         rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out_q   <= '0;
            dir_q        <= '0;
            irq_en_q     <= '0;
            irq_pol_q    <= '0;
            irq_status_q <= '0;
            rdata_q      <= '0;
            rvalid_q     <= 1'b0;
            irq_q        <= 1'b0;
        end else begin
            if (w_wr_out) data_out_q <= w_wdata;
            if (w_wr_dir) dir_q      <= w_wdata;
            if (w_wr_pol) irq_pol_q  <= w_wdata;
            irq_en_q     <= irq_en_d;
            irq_status_q <= irq_status_d;
            rdata_q      <= rdata_d;
            rvalid_q     <= bus.bus_re;
            irq_q        <= |(irq_status_d & irq_en_d);
        end
    end

    assign bus.bus_rdata  = rdata_q;
    assign bus.bus_rvalid = rvalid_q;
    assign gpio_port_out  = data_out_q;
    assign gpio_port_oe   = dir_q;
    assign irq            = irq_q;

endmodule

`default_nettype wire

// File: tb/tb_gpio_port_ctrl.sv
// +--------------------------------------------------------------------------+
// | tb_gpio_port_ctrl                                                        |
// | Self-checking bench: directed scenarios plus randomized traffic against  |
// | a register-level behavioural model.                                      |
// | Rev 1.0  initial release                                                 |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_gpio_port_ctrl;

    localparam int GW = 8;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int SS = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [GW-1:0] pins = '0;
    logic [GW-1:0] pout;
    logic [GW-1:0] poe;
    logic          irq;

    gpio_port_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_if ();

    gpio_port_ctrl #(
        .GPIO_WIDTH  (GW),
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .SYNC_STAGES (SS)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus_if),
        .gpio_port_in  (pins),
        .gpio_port_out (pout),
        .gpio_port_oe  (poe),
        .irq           (irq)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Register-level model: registers as plain variables, input path as a
    // history of pin samples (hist[0] newest), DATA_IN = sample SS-1 edges old.
    logic [GW-1:0] m_out, m_dir, m_en, m_pol, m_st, m_rdata;
    logic [GW-1:0] hist [SS+1];
    logic          m_rvalid, m_irq;

    always @(posedge clk) begin
        logic [GW-1:0] cur, prv, edges, wd;
        int off;
        if (!reset) begin
            m_out = '0; m_dir = '0; m_en = '0; m_pol = '0; m_st = '0;
            m_rdata = '0; m_rvalid = 1'b0;
            for (int k = 0; k <= SS; k++) hist[k] = '0;
        end else begin
            cur = hist[SS-1];
            prv = hist[SS];
            for (int i = 0; i < GW; i++)
                edges[i] = m_pol[i] ? (prv[i] & ~cur[i]) : (cur[i] & ~prv[i]);
            off = int'(bus_if.bus_addr) & 'h1C;
            wd  = bus_if.bus_wdata[GW-1:0];
            m_rvalid = bus_if.bus_re;
            if (bus_if.bus_re) begin
                case (off)
                    'h00:    m_rdata = cur;
                    'h04:    m_rdata = m_out;
                    'h08:    m_rdata = m_dir;
                    'h0C:    m_rdata = m_en;
                    'h10:    m_rdata = m_pol;
                    'h14:    m_rdata = m_st;
                    default: m_rdata = '0;
                endcase
            end
            if (bus_if.bus_we) begin
                case (off)
                    'h04:    m_out = wd;
                    'h08:    m_dir = wd;
                    'h0C:    m_en  = wd;
                    'h10:    m_pol = wd;
                    'h14:    m_st  = m_st & ~wd;
                    default: ;
                endcase
            end
            m_st = m_st | edges;
            for (int k = SS; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = pins;
        end
        m_irq = |(m_st & m_en);
        #1;
        check("model_out", 32'(pout), 32'(m_out));
        check("model_oe", 32'(poe), 32'(m_dir));
        check("model_irq", 32'(irq), 32'(m_irq));
        check("model_rvalid", 32'(bus_if.bus_rvalid), 32'(m_rvalid));
        if (m_rvalid) check("model_rdata", bus_if.bus_rdata, 32'(m_rdata));
    end

    // Bus tasks are entered and left just after a falling edge.
    task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
        bus_if.bus_addr  = a;
        bus_if.bus_wdata = d;
        bus_if.bus_we    = 1'b1;
        @(negedge clk);
        bus_if.bus_we    = 1'b0;
    endtask

    task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
        bus_if.bus_addr = a;
        bus_if.bus_re   = 1'b1;
        @(negedge clk);
        bus_if.bus_re   = 1'b0;
        d = bus_if.bus_rdata;
    endtask

    initial begin
        logic [31:0] d;
        bus_if.bus_addr  = '0;
        bus_if.bus_wdata = '0;
        bus_if.bus_we    = 1'b0;
        bus_if.bus_re    = 1'b0;
        repeat (3) @(negedge clk);

        // Reset held
        bus_read(5'h04, d);
        check("t1_rdata", d, 32'h0);
        check("t1_rvalid", 32'(bus_if.bus_rvalid), 32'h0);
        check("t1_out", 32'(pout), 32'h0);
        check("t1_oe", 32'(poe), 32'h0);
        check("t1_irq", 32'(irq), 32'h0);
        reset = 1'b1;
        @(negedge clk);

        // Direction and output data
        bus_write(5'h08, 32'hFFFF_FFFF);
        bus_write(5'h04, 32'h0000_00A5);
        check("t2_oe", 32'(poe), 32'hFF);
        check("t2_out", 32'(pout), 32'hA5);
        bus_read(5'h04, d);
        check("t2_rd_out", d, 32'hA5);
        bus_read(5'h08, d);
        check("t2_rd_dir_upper0", d, 32'hFF);
        bus_if.bus_addr = 5'h04; bus_if.bus_wdata = 32'h3C;
        bus_if.bus_we = 1'b1; bus_if.bus_re = 1'b1;
        @(negedge clk);
        bus_if.bus_we = 1'b0; bus_if.bus_re = 1'b0;
        check("t2_rw_prewrite", bus_if.bus_rdata, 32'hA5);
        bus_read(5'h05, d);
        check("t2_rd_alias", d, 32'h3C);
        bus_read(5'h18, d);
        check("t2_rd_unmapped", d, 32'h0);

        // Rising edge on pin0
        bus_write(5'h0C, 32'h01);
        pins = 8'h01;
        @(negedge clk);
        @(negedge clk);
        check("t3_irq_edge2", 32'(irq), 32'h0);
        @(negedge clk);
        check("t3_irq_edge3", 32'(irq), 32'h1);
        bus_read(5'h00, d);
        check("t3_data_in", d, 32'h01);
        bus_read(5'h14, d);
        check("t3_status", d, 32'h01);
        bus_write(5'h14, 32'h01);
        check("t3_irq_clr", 32'(irq), 32'h0);
        bus_read(5'h14, d);
        check("t3_status_clr", d, 32'h0);

        // Falling edge on pin3 with interrupt disabled
        bus_write(5'h10, 32'h08);
        bus_write(5'h0C, 32'h00);
        pins = 8'h09;
        repeat (4) @(negedge clk);
        pins = 8'h01;
        repeat (4) @(negedge clk);
        check("t4_irq_masked", 32'(irq), 32'h0);
        bus_read(5'h14, d);
        check("t4_status", d, 32'h08);
        bus_write(5'h0C, 32'h08);
        check("t4_irq_en", 32'(irq), 32'h1);
        bus_write(5'h14, 32'hFF);
        check("t4_irq_clr", 32'(irq), 32'h0);

        // Edge coincident with W1C: set wins
        bus_write(5'h0C, 32'h09);
        pins = 8'h00;
        repeat (4) @(negedge clk);
        pins = 8'h01;
        repeat (4) @(negedge clk);
        check("t5_irq_set", 32'(irq), 32'h1);
        pins = 8'h00;
        repeat (4) @(negedge clk);
        pins = 8'h01;
        @(negedge clk);
        @(negedge clk);
        bus_write(5'h14, 32'h01);
        check("t5_irq_kept", 32'(irq), 32'h1);
        bus_read(5'h14, d);
        check("t5_status_kept", d, 32'h01);

        // Async reset during a read with all status bits set
        bus_write(5'h0C, 32'hFF);
        bus_write(5'h10, 32'h00);
        pins = 8'h00;
        repeat (4) @(negedge clk);
        pins = 8'hFF;
        repeat (4) @(negedge clk);
        bus_read(5'h14, d);
        check("t6_status_ff", d, 32'hFF);
        bus_if.bus_addr = 5'h14;
        bus_if.bus_re   = 1'b1;
        @(posedge clk);
        #2;
        check("t6_rvalid_pre", 32'(bus_if.bus_rvalid), 32'h1);
        reset = 1'b0;
        #1;
        check("t6_rvalid_async", 32'(bus_if.bus_rvalid), 32'h0);
        check("t6_rdata_async", bus_if.bus_rdata, 32'h0);
        check("t6_irq_async", 32'(irq), 32'h0);
        check("t6_out_async", 32'(pout), 32'h0);
        @(negedge clk);
        bus_if.bus_re = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        bus_read(5'h14, d);
        check("t6_status_reset", d, 32'h0);
        repeat (4) @(negedge clk);
        check("t6_irq_disabled", 32'(irq), 32'h0);
        bus_read(5'h14, d);
        check("t6_status_resync", d, 32'hFF);

        // Randomized traffic checked by the model every cycle
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0)
                pins = pins ^ (GW'($urandom) & GW'($urandom));
            bus_if.bus_addr  = AW'($urandom_range(0, 31));
            bus_if.bus_wdata = $urandom;
            bus_if.bus_we    = ($urandom_range(0, 2) == 0);
            bus_if.bus_re    = ($urandom_range(0, 2) == 0);
            reset            = ($urandom_range(0, 599) != 0);
            @(negedge clk);
        end
        bus_if.bus_we = 1'b0;
        bus_if.bus_re = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
